// File: rtl/servo_pwm_gen.sv
// Four-channel servo PWM: samples angles once per frame, converts each to a pulse width with a serial divider.
// Latency: widths settle 80 cycles after frame_start; PWM outputs are registered (1 cycle from compare).
// Backpressure: none; angles are sampled only at frame start, later input changes wait for the next frame.
module servo_pwm_gen #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int PWM_HZ    = 50,
    parameter int MIN_US    = 1000,
    parameter int MAX_US    = 2000,
    parameter int MAX_ANGLE = 180
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] angle1,
    input  logic [7:0] angle2,
    input  logic [7:0] angle3,
    input  logic [7:0] angle4,
    output logic       PWM1,
    output logic       PWM2,
    output logic       PWM3,
    output logic       PWM4,
    output logic       frame_start,
    output logic       busy
);

    localparam int US_DIV   = CLK_HZ / 1_000_000;
    localparam int FRAME_US = 1_000_000 / PWM_HZ;
    localparam int SPAN     = MAX_US - MIN_US;
    localparam int PRE_W    = (US_DIV > 1) ? $clog2(US_DIV) : 1;
    localparam int US_W     = $clog2(FRAME_US);
    localparam int NUM_W    = $clog2(MAX_ANGLE * SPAN + 1);
    localparam int REM_W    = $clog2(2 * MAX_ANGLE);
    localparam int BIT_W    = $clog2(NUM_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV, S_STORE} state_t;

    logic [PRE_W-1:0] pre_cnt;
    logic [US_W-1:0]  us_cnt;
    logic             pre_wrap;

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       ch_q;
    logic [BIT_W-1:0] bit_q;
    logic [NUM_W-1:0] num_q;
    logic [REM_W-1:0] rem_q;
    logic [REM_W-1:0] trial;
    logic             div_ge;

    logic [7:0]       ang_in  [4];
    logic [7:0]       a_q     [4];
    logic [15:0]      width_q [4];
    logic [3:0]       pwm_q;

    function automatic logic [7:0] clamp_ang(input logic [7:0] a);
        return (32'(a) > MAX_ANGLE) ? 8'(MAX_ANGLE) : a;
    endfunction

    assign ang_in[0] = angle1;
    assign ang_in[1] = angle2;
    assign ang_in[2] = angle3;
    assign ang_in[3] = angle4;

    assign pre_wrap = (pre_cnt == PRE_W'(US_DIV - 1));

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            pre_cnt <= '0;
            us_cnt  <= '0;
        end else if (pre_wrap) begin
            pre_cnt <= '0;
            us_cnt  <= (us_cnt == US_W'(FRAME_US - 1)) ? '0 : us_cnt + 1'b1;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // Gated by reset so the held-at-zero counters do not look like a frame start.
    assign frame_start = !reset && (pre_cnt == '0) && (us_cnt == '0);
    assign busy        = (state_q != S_IDLE);

    always_ff @(posedge CLOCK_50) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (frame_start) state_d = S_LOAD;
            S_LOAD:  state_d = S_DIV;
            S_DIV:   if (bit_q == BIT_W'(NUM_W - 1)) state_d = S_STORE;
            S_STORE: state_d = (ch_q == 2'd3) ? S_IDLE : S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    // Restoring division: num_q shifts out dividend bits and shifts in quotient bits.
    assign trial  = {rem_q[REM_W-2:0], num_q[NUM_W-1]};
    assign div_ge = (trial >= REM_W'(MAX_ANGLE));

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            ch_q  <= '0;
            bit_q <= '0;
            num_q <= '0;
            rem_q <= '0;
            for (int i = 0; i < 4; i++) begin
                a_q[i]     <= '0;
                width_q[i] <= '0;
            end
        end else begin
            if (frame_start) begin
                for (int i = 0; i < 4; i++) a_q[i] <= clamp_ang(ang_in[i]);
            end
            case (state_q)
                S_IDLE: ch_q <= '0;
                S_LOAD: begin
                    num_q <= NUM_W'(a_q[ch_q]) * NUM_W'(SPAN);
                    rem_q <= '0;
                    bit_q <= '0;
                end
                S_DIV: begin
                    rem_q <= div_ge ? (trial - REM_W'(MAX_ANGLE)) : trial;
                    num_q <= {num_q[NUM_W-2:0], div_ge};
                    bit_q <= bit_q + 1'b1;
                end
                S_STORE: begin
                    width_q[ch_q] <= 16'(MIN_US) + 16'(num_q);
                    ch_q          <= ch_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            pwm_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++)
                pwm_q[i] <= enable && (32'(us_cnt) < 32'(width_q[i]));
        end
    end

    assign PWM1 = pwm_q[0];
    assign PWM2 = pwm_q[1];
    assign PWM3 = pwm_q[2];
    assign PWM4 = pwm_q[3];

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Bench for servo_pwm_gen with a scaled clock (2 cycles per us, 2500 us frame) to keep runs short.
module tb_servo_pwm_gen;

    localparam int US_DIV    = 2;
    localparam int FRAME_CYC = 5000;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic       enable   = 1'b1;
    logic [7:0] angle1   = 8'd0;
    logic [7:0] angle2   = 8'd0;
    logic [7:0] angle3   = 8'd0;
    logic [7:0] angle4   = 8'd0;
    logic       PWM1, PWM2, PWM3, PWM4;
    logic       frame_start, busy;
    logic [3:0] pwm;

    int checks   = 0;
    int failures = 0;
    int hi_cnt [4];
    int period;

    typedef struct packed {
        logic [7:0]  a1, a2, a3, a4;
        logic [15:0] w1, w2, w3, w4;
    } vec_t;
    vec_t vecs [4];

    servo_pwm_gen #(
        .CLK_HZ   (2_000_000),
        .PWM_HZ   (400),
        .MIN_US   (1000),
        .MAX_US   (2000),
        .MAX_ANGLE(180)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .enable     (enable),
        .angle1     (angle1),
        .angle2     (angle2),
        .angle3     (angle3),
        .angle4     (angle4),
        .PWM1       (PWM1),
        .PWM2       (PWM2),
        .PWM3       (PWM3),
        .PWM4       (PWM4),
        .frame_start(frame_start),
        .busy       (busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;
    assign pwm = {PWM4, PWM3, PWM2, PWM1};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_angles(input logic [7:0] a1, a2, a3, a4);
        angle1 = a1; angle2 = a2; angle3 = a3; angle4 = a4;
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timeout waiting for frame_start", name);
    endtask

    task automatic wait_fs(input string name);
        for (int c = 0; c < FRAME_CYC + 1000; c++) begin
            @(negedge CLOCK_50);
            if (frame_start) return;
        end
        timeout(name);
    endtask

    // Called on the negedge of a frame-start cycle; returns on the next one.
    // kind 1: angle2 -> 180, kind 2: enable off (back on at 4500), kind 3: assert reset and return.
    task automatic measure_frame(input int act_cyc, input int kind);
        for (int i = 0; i < 4; i++) hi_cnt[i] = 0;
        period = 0;
        for (int c = 1; c <= FRAME_CYC + 1000; c++) begin
            @(negedge CLOCK_50);
            if (frame_start) begin
                period = c;
                return;
            end
            for (int i = 0; i < 4; i++) if (pwm[i]) hi_cnt[i]++;
            if (c == act_cyc) begin
                case (kind)
                    1: angle2 = 8'd180;
                    2: enable = 1'b0;
                    3: begin reset = 1'b1; return; end
                    default: ;
                endcase
            end
            if (kind == 2 && c == 4500) enable = 1'b1;
        end
        timeout("measure_frame");
    endtask

    // Expects reset to have been raised just before the coming posedge.
    task automatic reset_check(input string tag, input int e0, e1, e2, e3);
        int n;
        @(negedge CLOCK_50);
        check({tag, "_pwm"}, int'(pwm), 0);
        check({tag, "_fs"}, int'(frame_start), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_counters"}, int'(dut.us_cnt) + int'(dut.pre_cnt), 0);
        check({tag, "_widths"}, int'(dut.width_q[0]) + int'(dut.width_q[1]) +
                                int'(dut.width_q[2]) + int'(dut.width_q[3]), 0);
        reset = 1'b0;
        #1;
        check({tag, "_fs_release"}, int'(frame_start), 1);
        @(negedge CLOCK_50);
        check({tag, "_fs_oneshot"}, int'(frame_start), 0);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge CLOCK_50);
        end
        check({tag, "_busy_len"}, n, 80);
        check({tag, "_width1"}, int'(dut.width_q[0]), e0);
        check({tag, "_width2"}, int'(dut.width_q[1]), e1);
        check({tag, "_width3"}, int'(dut.width_q[2]), e2);
        check({tag, "_width4"}, int'(dut.width_q[3]), e3);
    endtask

    initial begin
        int w [4];

        vecs[0] = '{8'd0,   8'd90,  8'd180, 8'd45,  16'd1000, 16'd1500, 16'd2000, 16'd1250};
        vecs[1] = '{8'd200, 8'd1,   8'd180, 8'd0,   16'd2000, 16'd1005, 16'd2000, 16'd1000};
        vecs[2] = '{8'd90,  8'd255, 8'd10,  8'd179, 16'd1500, 16'd2000, 16'd1055, 16'd1994};
        vecs[3] = '{8'd181, 8'd45,  8'd135, 8'd1,   16'd2000, 16'd1250, 16'd1750, 16'd1005};

        set_angles(vecs[0].a1, vecs[0].a2, vecs[0].a3, vecs[0].a4);
        repeat (3) @(negedge CLOCK_50);
        reset_check("rst0", 1000, 1500, 2000, 1250);
        wait_fs("first_frame");

        for (int v = 0; v < 4; v++) begin
            set_angles(vecs[v].a1, vecs[v].a2, vecs[v].a3, vecs[v].a4);
            w = '{int'(vecs[v].w1), int'(vecs[v].w2), int'(vecs[v].w3), int'(vecs[v].w4)};
            measure_frame(0, 0);
            for (int i = 0; i < 4; i++)
                check($sformatf("vec%0d_high%0d", v, i + 1), hi_cnt[i], w[i] * US_DIV);
            check($sformatf("vec%0d_period", v), period, FRAME_CYC);
        end

        // Mid-frame angle change waits for the next frame.
        set_angles(8'd0, 8'd0, 8'd0, 8'd0);
        measure_frame(1000, 1);
        check("midchange_cur_high2", hi_cnt[1], 2000);
        check("midchange_cur_high1", hi_cnt[0], 2000);
        measure_frame(0, 0);
        check("midchange_next_high2", hi_cnt[1], 4000);
        check("midchange_next_high1", hi_cnt[0], 2000);

        // Enable drop at us_cnt 1200, restored before the next frame.
        angle1 = 8'd180;
        measure_frame(2400, 2);
        check("enable_cut_high1", hi_cnt[0], 2400);
        measure_frame(0, 0);
        check("enable_back_high1", hi_cnt[0], 4000);
        check("enable_back_period", period, FRAME_CYC);

        // Reset mid-pulse (us_cnt 1500).
        measure_frame(3000, 3);
        reset_check("rst_pulse", 2000, 2000, 1000, 1000);
        wait_fs("after_rst_pulse");

        // Reset mid-conversion.
        measure_frame(30, 3);
        reset_check("rst_conv", 2000, 2000, 1000, 1000);
        wait_fs("after_rst_conv");
        measure_frame(0, 0);
        check("post_reset_high1", hi_cnt[0], 4000);
        check("post_reset_high2", hi_cnt[1], 4000);
        check("post_reset_high3", hi_cnt[2], 2000);
        check("post_reset_high4", hi_cnt[3], 2000);
        check("post_reset_period", period, FRAME_CYC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/servo_pwm_gen.md
# servo_pwm_gen

Four-channel hobby-servo PWM generator that consumes the four 8-bit joint angles (degrees) produced by the key/switch angle-entry stage and drives the arm's servo signal pins. Once per 20 ms frame it samples all four angles, clamps them, converts each to a pulse width in microseconds with a small sequential divider, and emits one pulse per channel per frame. Sits directly downstream of the angle-entry block and directly drives the GPIO header.

## Interface
Parameters:
- CLK_HZ, 50_000_000, system clock frequency; must be an integer multiple of 1_000_000
- PWM_HZ, 50, frame rate; 1_000_000/PWM_HZ must be an integer
- MIN_US, 1000, pulse width at angle 0
- MAX_US, 2000, pulse width at angle MAX_ANGLE
- MAX_ANGLE, 180, largest legal angle; larger inputs are clamped

Ports:
- CLOCK_50  in  1  system clock; one clock, all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = drive pulses; 0 = all PWM outputs held low
- angle1..angle4  in  8 each  requested angles from the angle-entry stage, unsigned degrees
- PWM1..PWM4  out  1 each  registered servo pulse outputs
- frame_start  out  1  one-cycle pulse on the cycle the angles are sampled
- busy  out  1  high while the width conversion FSM is not IDLE

## Operation
- Derived constants: US_DIV = CLK_HZ/1_000_000; FRAME_US = 1_000_000/PWM_HZ; SPAN = MAX_US-MIN_US.
- Prescaler pre_cnt counts 0..US_DIV-1 and wraps; us_cnt increments on each pre_cnt wrap, counting 0..FRAME_US-1, then wraps to 0.
- Frame start = (us_cnt==0 && pre_cnt==0). On that cycle:
  - each angleN is sampled into shadow register aN, clamped to MAX_ANGLE if larger
  - frame_start = 1
  - the FSM leaves IDLE
- Conversion FSM, one channel at a time, N = 1..4:
  - IDLE → LOAD: numerator = aN*SPAN, at most 18 bits with defaults
  - LOAD → DIV: restoring divide by MAX_ANGLE, one quotient bit per cycle, 18 cycles
  - DIV → STORE: widthN = MIN_US + floor(aN*SPAN/MAX_ANGLE)
  - STORE → LOAD for N+1, or → IDLE after channel 4
  - Total latency is 4*(1+18+1) = 80 cycles from frame start to busy low.
- Widths change only in STORE. The aN and widthN registers are not touched outside the frame-start and STORE cycles.
- Output: PWMn <= enable && (us_cnt < widthN), registered every cycle.
- Angle input changes mid-frame have no effect until the next frame start.
- No glitch on width update: STORE always happens while us_cnt < MIN_US, so the compare result is already 1 before and after the update.
- enable deasserted mid-pulse: PWM goes low the next cycle. Counters and the FSM keep running. When enable reasserts, the output resumes according to the compare for the remainder of the current frame.

## Timing
- Reset, checked on the cycle after reset is sampled high:
  - pre_cnt = 0, us_cnt = 0
  - FSM in IDLE; all aN = 0; all widthN = 0
  - PWM1..4 = 0; frame_start = 0; busy = 0
- Reset asserted mid-conversion or mid-pulse aborts everything to the reset values within one cycle.
- First cycle after reset is released is a frame start: frame_start = 1 that cycle, and busy = 1 from the next cycle for 80 cycles.
- First frame after reset: widthN = 0 until its STORE, so the first pulse is shortened by up to 80 cycles. All later frames are exact.
- Steady state: if frame start is cycle F, PWMn is high on cycles F+1 .. F+widthN*US_DIV inclusive. The pulse lasts exactly widthN*US_DIV cycles and the period is exactly FRAME_US*US_DIV cycles.
- Arithmetic: unsigned only. Divider remainder is discarded, so the result is floored. widthN is 16 bits; maximum MAX_US must be less than FRAME_US.

## Test plan
- Reset, then angle1 = 0, angle2 = 90, angle3 = 180, angle4 = 45, enable = 1. In the second frame, require high times of 50,000 / 75,000 / 100,000 / 62,500 cycles, and a period of 1,000,000 cycles on all channels.
- angle1 = 200: clamped, width1 = 2000 µs (100,000 cycles high). angle1 = 1: width1 = 1005 µs (50,250 cycles high).
- Change angle2 from 0 to 180 at us_cnt = 500 of a frame: the current pulse stays 1000 µs; the next frame's pulse is 2000 µs.
- busy rises the cycle after frame_start and falls exactly 80 cycles later. widthN values after busy falls match the formula.
- enable = 0 at us_cnt = 1200 with angle = 180: PWM low the next cycle and low for the remainder of the frame. enable = 1 before the next frame: the full 2000 µs pulse is produced.
- Assert reset at us_cnt = 1500, mid-pulse, and mid-conversion: all outputs 0 the next cycle; on release, frame_start fires on the first cycle.
